// File: rtl/corelet_ctrl.sv
// corelet_ctrl: instruction sequencer that walks the corelet through one
// convolution tile (weight-stationary or output-stationary) and issues the
// matching xmem reads and pmem writes.
module corelet_ctrl #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_nij = 36,
    parameter int unsigned len_kij = 9,
    parameter int unsigned xaddr_w = 11,
    parameter int unsigned paddr_w = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode_sel,
    input  logic               o_valid,
    input  logic               o_ready,
    output logic [7:0]         inst,
    output logic               mode,
    output logic               output_en,
    output logic               xmem_cen,
    output logic [xaddr_w-1:0] xmem_addr,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [paddr_w-1:0] pmem_addr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [3:0] {
        StIdle, StWLoad, StKLoad, StKFlush, StALoad, StExec, StDrain,
        StOsLoad, StOsExec, StOsFlush, StOsOut, StOsDrain, StDone
    } state_e;

    localparam logic [15:0]  ColLast   = 16'(col - 1);
    localparam logic [15:0]  NijLast   = 16'(len_nij - 1);
    localparam logic [15:0]  KijLast   = 16'(len_kij - 1);
    localparam logic [15:0]  FlushLast = 16'(row + col - 1);
    localparam int unsigned  WBase     = 1024;

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d, k_q, k_d;
    logic                 mode_q, mode_d;
    logic                 acc_q, acc_d, ififo_wr_q, ififo_wr_d, ififo_rd_q, ififo_rd_d;
    logic                 l0_rd_q, l0_rd_d, l0_wr_q, l0_wr_d;
    logic [1:0]           inst_w_q, inst_w_d;
    logic                 output_en_q, output_en_d;
    logic                 xmem_cen_q, xmem_cen_d, pmem_cen_q, pmem_cen_d, pmem_wen_q, pmem_wen_d;
    logic [xaddr_w-1:0]   xmem_addr_q, xmem_addr_d;
    logic [paddr_w-1:0]   pmem_addr_q, pmem_addr_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 ofifo_rd;

    // Next-state, counter and next-output computation; outputs describe the following cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        mode_d      = mode_q;
        xmem_cen_d  = 1'b1;
        xmem_addr_d = xmem_addr_q;
        pmem_cen_d  = 1'b1;
        pmem_wen_d  = 1'b1;
        pmem_addr_d = pmem_addr_q;
        l0_rd_d     = 1'b0;
        ififo_rd_d  = 1'b0;
        inst_w_d    = 2'b00;
        ofifo_rd    = 1'b0;
        // xmem data arrives one cycle after the read, so fifo writes trail the read strobe
        l0_wr_d     = ~xmem_cen_q;
        ififo_wr_d  = ~xmem_cen_q & mode_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = mode_sel ? StOsLoad : StWLoad;
                    mode_d  = mode_sel;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            end
            StWLoad: begin
                xmem_cen_d  = 1'b0;
                xmem_addr_d = xaddr_w'(WBase + col * k_q + cnt_q);
                if (cnt_q == ColLast) begin
                    cnt_d   = '0;
                    state_d = StKLoad;
                end else cnt_d = cnt_q + 16'd1;
            end
            StKLoad: begin
                l0_rd_d  = 1'b1;
                inst_w_d = 2'b01;
                if (cnt_q == ColLast) begin
                    cnt_d   = '0;
                    state_d = StKFlush;
                end else cnt_d = cnt_q + 16'd1;
            end
            StKFlush, StOsFlush: begin
                if (cnt_q == FlushLast) begin
                    cnt_d   = '0;
                    state_d = (state_q == StOsFlush) ? StOsOut : StALoad;
                end else cnt_d = cnt_q + 16'd1;
            end
            StALoad, StOsLoad: begin
                xmem_cen_d  = 1'b0;
                xmem_addr_d = xaddr_w'(cnt_q);
                if (cnt_q == ((state_q == StOsLoad) ? KijLast : NijLast)) begin
                    cnt_d   = '0;
                    state_d = (state_q == StOsLoad) ? StOsExec : StExec;
                end else cnt_d = cnt_q + 16'd1;
            end
            StExec, StOsExec: begin
                // a full OFIFO freezes the array: no strobes and no count advance
                if (o_ready) begin
                    l0_rd_d    = 1'b1;
                    ififo_rd_d = (state_q == StOsExec);
                    inst_w_d   = 2'b10;
                    if (cnt_q == ((state_q == StOsExec) ? KijLast : NijLast)) begin
                        cnt_d   = '0;
                        state_d = (state_q == StOsExec) ? StOsFlush : StDrain;
                    end else cnt_d = cnt_q + 16'd1;
                end
            end
            StDrain, StOsDrain: begin
                // read only when a row is present this cycle; the psum lands in pmem next cycle
                if (o_valid) begin
                    ofifo_rd    = 1'b1;
                    pmem_cen_d  = 1'b0;
                    pmem_wen_d  = 1'b0;
                    pmem_addr_d = paddr_w'(len_nij * k_q + cnt_q);
                    if (cnt_q == ((state_q == StOsDrain) ? ColLast : NijLast)) begin
                        cnt_d = '0;
                        if (state_q == StOsDrain || k_q == KijLast) begin
                            state_d = StDone;
                        end else begin
                            k_d     = k_q + 16'd1;
                            state_d = StWLoad;
                        end
                    end else cnt_d = cnt_q + 16'd1;
                end
            end
            StOsOut: state_d = StOsDrain;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Status strobes track the state they describe
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        output_en_d = (state_d == StOsOut);
        acc_d       = (state_d == StDrain) && (k_d != '0);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            acc_q       <= 1'b0;
            ififo_wr_q  <= 1'b0;
            ififo_rd_q  <= 1'b0;
            l0_rd_q     <= 1'b0;
            l0_wr_q     <= 1'b0;
            inst_w_q    <= 2'b00;
            output_en_q <= 1'b0;
            xmem_cen_q  <= 1'b1;
            xmem_addr_q <= '0;
            pmem_cen_q  <= 1'b1;
            pmem_wen_q  <= 1'b1;
            pmem_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            ififo_wr_q  <= ififo_wr_d;
            ififo_rd_q  <= ififo_rd_d;
            l0_rd_q     <= l0_rd_d;
            l0_wr_q     <= l0_wr_d;
            inst_w_q    <= inst_w_d;
            output_en_q <= output_en_d;
            xmem_cen_q  <= xmem_cen_d;
            xmem_addr_q <= xmem_addr_d;
            pmem_cen_q  <= pmem_cen_d;
            pmem_wen_q  <= pmem_wen_d;
            pmem_addr_q <= pmem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ofifo_rd is qualified by the live o_valid so it can never pop an empty OFIFO
    assign inst      = {acc_q, ofifo_rd, ififo_wr_q, ififo_rd_q, l0_rd_q, l0_wr_q, inst_w_q};
    assign mode      = mode_q;
    assign output_en = output_en_q;
    assign xmem_cen  = xmem_cen_q;
    assign xmem_addr = xmem_addr_q;
    assign pmem_cen  = pmem_cen_q;
    assign pmem_wen  = pmem_wen_q;
    assign pmem_addr = pmem_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: instance A (2 kernel positions) covers WS
// sequencing and stalls, instance B (9 kernel positions) covers reset abort and OS.
module tb_corelet_ctrl;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, mode_sel, o_valid, o_ready;
    logic [7:0]  inst_a, inst_b;
    logic        mode_a, mode_b, oen_a, oen_b, xcen_a, xcen_b;
    logic        pcen_a, pcen_b, pwen_a, pwen_b, busy_a, busy_b, done_a, done_b;
    logic [10:0] xaddr_a, xaddr_b, paddr_a, paddr_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] e_inst;
    logic       e_xcen, e_pcen, e_busy, e_done;
    int         e_xaddr, e_paddr;
    int         cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, first, last, first_rd, at_oe, at_done;

    always #5 clk = ~clk;

    corelet_ctrl #(.row(8), .col(8), .len_nij(4), .len_kij(2), .xaddr_w(11), .paddr_w(11)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode_sel(mode_sel), .o_valid(o_valid),
        .o_ready(o_ready), .inst(inst_a), .mode(mode_a), .output_en(oen_a), .xmem_cen(xcen_a),
        .xmem_addr(xaddr_a), .pmem_cen(pcen_a), .pmem_wen(pwen_a), .pmem_addr(paddr_a),
        .busy(busy_a), .done(done_a)
    );

    corelet_ctrl #(.row(8), .col(8), .len_nij(4), .len_kij(9), .xaddr_w(11), .paddr_w(11)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode_sel(mode_sel), .o_valid(o_valid),
        .o_ready(o_ready), .inst(inst_b), .mode(mode_b), .output_en(oen_b), .xmem_cen(xcen_b),
        .xmem_addr(xaddr_b), .pmem_cen(pcen_b), .pmem_wen(pwen_b), .pmem_addr(paddr_b),
        .busy(busy_b), .done(done_b)
    );

    // One comparison: count it, report it if it differs
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-derived WS timeline for col=8, row=8, len_nij=4: 44 cycles per kernel position,
    // cycle c counted from the edge that accepted start.
    task automatic exp_ws(input int c, input int nkij);
        int total, k, o;
        total   = 44 * nkij;
        e_inst  = 8'h00;
        e_xcen  = 1'b1;
        e_pcen  = 1'b1;
        e_xaddr = 0;
        e_paddr = 0;
        e_busy  = (c <= total);
        e_done  = (c == total);
        if (c < total) begin
            k = c / 44;
            o = c % 44;
            if (o >= 1 && o <= 8) begin e_xcen = 1'b0; e_xaddr = 1024 + 8 * k + o - 1; end
            if (o >= 33 && o <= 36) begin e_xcen = 1'b0; e_xaddr = o - 33; end
            if ((o >= 2 && o <= 9) || (o >= 34 && o <= 37)) e_inst = e_inst | 8'h04;
            if (o >= 9 && o <= 16) e_inst = e_inst | 8'h09;
            if (o >= 37 && o <= 40) e_inst = e_inst | 8'h0A;
            if (o >= 40 && o <= 43) e_inst = e_inst | ((k != 0) ? 8'hC0 : 8'h40);
        end
        if (c >= 1 && c <= total) begin
            k = (c - 1) / 44;
            o = (c - 1) % 44;
            if (o >= 40 && o <= 43) begin e_pcen = 1'b0; e_paddr = 4 * k + o - 40; end
        end
    endtask

    task automatic reset_duts();
        @(negedge clk);
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        mode_sel = 1'b0; o_valid = 1'b0; o_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        mode_sel = 1'b0; o_valid = 1'b0; o_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset a", {inst_a, mode_a, oen_a, xcen_a, pcen_a, pwen_a, busy_a, done_a},
                 {8'h00, 7'b0011100});
        check_eq("reset b", {inst_b, mode_b, oen_b, xcen_b, pcen_b, pwen_b, busy_b, done_b},
                 {8'h00, 7'b0011100});
        check_eq("reset addr", {xaddr_a, paddr_a, xaddr_b, paddr_b}, 0);
        reset = 1'b1;
        @(negedge clk);

        // WS full run, o_valid high, with start (and mode_sel=1) pulsed while busy
        start_a = 1'b1; o_valid = 1'b1; o_ready = 1'b1;
        cnt0 = 0;
        for (int c = 0; c < 96; c++) begin
            @(posedge clk); #1;
            start_a  = (c == 20 || c == 60);
            mode_sel = start_a;
            @(negedge clk);
            exp_ws(c, 2);
            check_eq($sformatf("ws c%0d ctl", c),
                     {inst_a, xcen_a, pcen_a, pwen_a, busy_a, done_a, mode_a},
                     {e_inst, e_xcen, e_pcen, e_pcen, e_busy, e_done, 1'b0});
            if (!e_xcen) check_eq($sformatf("ws c%0d xaddr", c), xaddr_a, e_xaddr);
            if (!e_pcen) check_eq($sformatf("ws c%0d paddr", c), paddr_a, e_paddr);
            if (done_a) cnt0++;
        end
        check_eq("ws done pulses", cnt0, 1);

        // o_valid 1,0,0,1 then 1,1 in the first drain
        reset_duts();
        start_a = 1'b1;
        for (int c = 0; c < 47; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            case (c)
                40, 43, 44, 45: o_valid = 1'b1;
                default:        o_valid = 1'b0;
            endcase
            @(negedge clk);
            if (c >= 40 && c <= 45)
                check_eq($sformatf("stall rd c%0d", c), {inst_a[7], inst_a[6]},
                         {1'b0, (c == 40 || c >= 43)});
            if (c >= 41 && c <= 46)
                check_eq($sformatf("stall pcen c%0d", c), pcen_a, !(c == 41 || c >= 44));
            if (c == 41) check_eq("stall paddr0", paddr_a, 0);
            if (c == 44) check_eq("stall paddr1", paddr_a, 1);
            if (c == 46) check_eq("stall paddr3", paddr_a, 3);
        end

        // o_ready low for three cycles mid-EXEC
        reset_duts();
        start_a = 1'b1; o_valid = 1'b1;
        cnt0 = 0; first = -1; last = -1; first_rd = -1;
        for (int c = 0; c < 51; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            o_ready = !(c >= 37 && c <= 39);
            @(negedge clk);
            if (inst_a[3] && inst_a[1:0] == 2'b10) begin
                cnt0++;
                if (first < 0) first = c;
                last = c;
            end
            if (inst_a[6] && first_rd < 0) first_rd = c;
        end
        check_eq("ready exec count", cnt0, 4);
        check_eq("ready exec first", first, 37);
        check_eq("ready exec span", last - first + 1, 7);
        check_eq("ready first ofifo_rd", first_rd, 43);

        // Reset asserted during EXEC of k=3, then a fresh start from k=0
        reset_duts();
        start_b = 1'b1; o_valid = 1'b1; o_ready = 1'b1;
        for (int c = 0; c < 171; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            @(negedge clk);
            if (c == 170) check_eq("k3 exec inst", inst_b, 8'h0A);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        check_eq("abort outputs", {inst_b, busy_b, xcen_b, pcen_b, done_b}, {8'h00, 5'b00110});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        for (int c = 0; c < 42; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            @(negedge clk);
            if (c == 0) check_eq("restart busy", busy_b, 1'b1);
            if (c == 1) check_eq("restart xmem", {xcen_b, xaddr_b}, {1'b0, 11'd1024});
            if (c == 2) check_eq("restart l0_wr", inst_b, 8'h04);
            if (c == 41) check_eq("restart pmem", {pcen_b, paddr_b}, {1'b0, 11'd0});
        end

        // OS run, 9 kernel positions
        reset_duts();
        start_b = 1'b1; mode_sel = 1'b1; o_valid = 1'b1; o_ready = 1'b1;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; cnt4 = 0; cnt5 = 0; cnt6 = 0;
        at_oe = -1; at_done = -1; last = -1;
        for (int c = 0; c < 51; c++) begin
            @(posedge clk); #1;
            start_b  = 1'b0;
            mode_sel = 1'b0;
            @(negedge clk);
            if (inst_b[5] && inst_b[2]) cnt0++;
            if (inst_b[4] && inst_b[3] && inst_b[1:0] == 2'b10) cnt1++;
            if (oen_b) begin cnt2++; at_oe = c; end
            if (inst_b[6]) cnt3++;
            if (inst_b[7]) cnt4++;
            if (done_b) begin cnt5++; at_done = c; end
            if (!pcen_b && !pwen_b) begin cnt6++; last = int'(paddr_b); end
            if (c == 1) check_eq("os xaddr first", {xcen_b, xaddr_b}, {1'b0, 11'd0});
            if (c == 9) check_eq("os xaddr last", {xcen_b, xaddr_b}, {1'b0, 11'd8});
            if (c == 2) check_eq("os load inst", inst_b, 8'h24);
            if (c == 10) check_eq("os load+exec inst", inst_b, 8'h3E);
            if (c == 11) check_eq("os exec inst", inst_b, 8'h1A);
            if (c == 5) check_eq("os mode", mode_b, 1'b1);
            if (c == 44) check_eq("os idle busy", busy_b, 1'b0);
        end
        check_eq("os fill count", cnt0, 9);
        check_eq("os exec count", cnt1, 9);
        check_eq("os output_en count", cnt2, 1);
        check_eq("os output_en cycle", at_oe, 34);
        check_eq("os ofifo_rd count", cnt3, 8);
        check_eq("os acc count", cnt4, 0);
        check_eq("os done count", cnt5, 1);
        check_eq("os done cycle", at_done, 43);
        check_eq("os pmem writes", cnt6, 8);
        check_eq("os last paddr", last, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
